// File: rtl/serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the digit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Step counter must hold N without wrapping, hence the extra bit.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_digit_adder.sv
// Half-adder cell: one-bit sum and carry of two inputs.
// Combinational, zero cycles.
// No flow control.
module half_adder (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

// Ripple adder over one DIGIT-wide slice, full adders built from two half adders plus OR.
// Combinational, zero cycles.
// No flow control; msb_cin exposes the carry into the slice's top bit for overflow.
module digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             cin,
    output logic [DIGIT-1:0] s,
    output logic             cout,
    output logic             msb_cin
);
    logic [DIGIT:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        logic s1, c1, c2;

        half_adder u_ha0 (.x(x[i]), .y(y[i]), .s(s1),   .c(c1));
        half_adder u_ha1 (.x(s1),   .y(c[i]), .s(s[i]), .c(c2));

        assign c[i+1] = c1 | c2;
    end

    assign cout    = c[DIGIT];
    assign msb_cin = c[DIGIT-1];
endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder consuming DIGIT bits of each operand per clock with a registered carry.
// Latency N = WIDTH/DIGIT cycles from the accepting edge to the done pulse.
// start is ignored while busy; a new request is accepted in IDLE or in the DONE cycle.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, work, work_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             accept, last_step;

    logic [DIGIT-1:0] dig_s;
    logic             dig_cout, dig_msb_cin;

    digit_adder #(.DIGIT(DIGIT)) u_digit (
        .x       (a_sh[DIGIT-1:0]),
        .y       (b_sh[DIGIT-1:0]),
        .cin     (carry),
        .s       (dig_s),
        .cout    (dig_cout),
        .msb_cin (dig_msb_cin)
    );

    assign accept    = start && (state != RUN);
    assign last_step = (state == RUN) && (cnt == CW'(N - 1));
    // New digit enters at the top so after N steps the LSB digit lands at bit 0.
    assign work_nxt  = (work >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            work  <= '0;
            carry <= c_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> DIGIT;
            b_sh  <= b_sh >> DIGIT;
            work  <= work_nxt;
            carry <= dig_cout;
            cnt   <= cnt + CW'(1);
            if (last_step) begin
                sum      <= work_nxt;
                c_out    <= dig_cout;
                overflow <= dig_msb_cin ^ dig_cout;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed checks of serial_adder at 8/1, 16/4 and 16/16 (WIDTH/DIGIT).
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        st8, ci8, busy8, done8, co8, ov8;
    logic [7:0]  a8, b8, sum8;
    logic        st4, ci4, busy4, done4, co4, ov4;
    logic [15:0] a4, b4, sum4;
    logic        st16, ci16, busy16, done16, co16, ov16;
    logic [15:0] a16, b16, sum16;

    int pass_cnt = 0;
    int total    = 0;

    serial_adder #(.WIDTH(8), .DIGIT(1)) u_w8d1 (
        .clk(clk), .rst_n(rst_n), .start(st8), .a(a8), .b(b8), .c_in(ci8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(co8), .overflow(ov8));

    serial_adder #(.WIDTH(16), .DIGIT(4)) u_w16d4 (
        .clk(clk), .rst_n(rst_n), .start(st4), .a(a4), .b(b4), .c_in(ci4),
        .busy(busy4), .done(done4), .sum(sum4), .c_out(co4), .overflow(ov4));

    serial_adder #(.WIDTH(16), .DIGIT(16)) u_w16d16 (
        .clk(clk), .rst_n(rst_n), .start(st16), .a(a16), .b(b16), .c_in(ci16),
        .busy(busy16), .done(done16), .sum(sum16), .c_out(co16), .overflow(ov16));

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 400us");
        $fatal(1);
    end

    function automatic logic sel_done(input int sel);
        case (sel)
            0:       return done8;
            1:       return done4;
            default: return done16;
        endcase
    endfunction

    function automatic logic sel_busy(input int sel);
        case (sel)
            0:       return busy8;
            1:       return busy4;
            default: return busy16;
        endcase
    endfunction

    // Stimulus only: pulse start at one instance, then count edges until done and busy samples.
    task automatic run_op(input int sel, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, output int lat, output int busy_n);
        case (sel)
            0:       begin a8  = a[7:0]; b8  = b[7:0]; ci8  = ci; st8  = 1'b1; end
            1:       begin a4  = a;      b4  = b;      ci4  = ci; st4  = 1'b1; end
            default: begin a16 = a;      b16 = b;      ci16 = ci; st16 = 1'b1; end
        endcase
        @(posedge clk); #1;
        st8 = 1'b0; st4 = 1'b0; st16 = 1'b0;
        a8 = 8'h5A; b8 = 8'hC3; a4 = 16'h1234; b4 = 16'h4321; a16 = 16'hBEEF; b16 = 16'h0F0F;
        lat = 0; busy_n = 0;
        while (!sel_done(sel) && lat < 40) begin
            if (sel_busy(sel)) busy_n++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st8 = 1'b1; a8 = 8'h33; b8 = 8'h44; ci8 = 1'b1;
        st4 = 1'b1; a4 = 16'h1111; b4 = 16'h2222; ci4 = 1'b0;
        st16 = 1'b1; a16 = 16'h3333; b16 = 16'h4444; ci16 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy8); else pass_cnt++;
        total++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done8); else pass_cnt++;
        total++; if (sum8 !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum8); else pass_cnt++;
        total++; if (co8 !== 1'b0) $display("FAIL reset_c_out: got %b expected 0", co8); else pass_cnt++;
        total++; if (ov8 !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", ov8); else pass_cnt++;
        total++; if ({busy4, done4, busy16, done16} !== 4'b0000)
            $display("FAIL reset_wide: got %b expected 0000", {busy4, done4, busy16, done16}); else pass_cnt++;
        st8 = 1'b0; st4 = 1'b0; st16 = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat, bn;
        run_op(0, 16'h000F, 16'h0001, 1'b0, lat, bn);
        total++; if (lat !== 8) $display("FAIL basic_latency: got %0d expected 8", lat); else pass_cnt++;
        total++; if (bn !== 8) $display("FAIL basic_busy_cycles: got %0d expected 8", bn); else pass_cnt++;
        total++; if (busy8 !== 1'b0) $display("FAIL basic_busy_in_done: got %b expected 0", busy8); else pass_cnt++;
        total++; if ({co8, ov8, sum8} !== {2'b00, 8'h10})
            $display("FAIL basic_result: got co=%b ov=%b sum=%h expected co=0 ov=0 sum=10", co8, ov8, sum8); else pass_cnt++;
        @(posedge clk); #1;
        total++; if (done8 !== 1'b0) $display("FAIL basic_done_width: got %b expected 0", done8); else pass_cnt++;
        total++; if (sum8 !== 8'h10) $display("FAIL basic_sum_hold: got %h expected 10", sum8); else pass_cnt++;
    endtask

    task automatic test_carry();
        int lat, bn;
        run_op(0, 16'h00FF, 16'h0001, 1'b0, lat, bn);
        total++; if ({co8, ov8, sum8} !== {2'b10, 8'h00})
            $display("FAIL carry_wrap: got co=%b ov=%b sum=%h expected co=1 ov=0 sum=00", co8, ov8, sum8); else pass_cnt++;
        @(posedge clk); #1;
        run_op(0, 16'h007F, 16'h0000, 1'b1, lat, bn);
        total++; if ({co8, ov8, sum8} !== {2'b01, 8'h80})
            $display("FAIL carry_overflow: got co=%b ov=%b sum=%h expected co=0 ov=1 sum=80", co8, ov8, sum8); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int t;
        st8 = 1'b1; a8 = 8'h05; b8 = 8'h03; ci8 = 1'b0;
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        a8 = 8'hAA;
        t = 0;
        while (!done8 && t < 20) begin @(posedge clk); #1; t++; end
        total++; if (sum8 !== 8'h08) $display("FAIL b2b_first_sum: got %h expected 08", sum8); else pass_cnt++;
        @(posedge clk); #1;
        total++; if ({done8, busy8} !== 2'b01)
            $display("FAIL b2b_relaunch: got done=%b busy=%b expected done=0 busy=1", done8, busy8); else pass_cnt++;
        t = 1;
        while (!done8 && t < 20) begin @(posedge clk); #1; t++; end
        total++; if (t !== 9) $display("FAIL b2b_period: got %0d expected 9", t); else pass_cnt++;
        total++; if (sum8 !== 8'hAD) $display("FAIL b2b_second_sum: got %h expected AD", sum8); else pass_cnt++;
        st8 = 1'b0;
        t = 0;
        while ((busy8 || done8) && t < 30) begin @(posedge clk); #1; t++; end
        total++; if (t >= 30) $display("FAIL b2b_drain: got timeout expected idle"); else pass_cnt++;
    endtask

    task automatic test_reset_mid_run();
        int lat, bn, t, dones;
        st8 = 1'b1; a8 = 8'h0F; b8 = 8'h01; ci8 = 1'b0;
        @(posedge clk); #1;
        st8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        total++; if ({busy8, done8} !== 2'b00)
            $display("FAIL abort_flags: got busy=%b done=%b expected 0 0", busy8, done8); else pass_cnt++;
        total++; if (sum8 !== 8'h00) $display("FAIL abort_sum: got %h expected 00", sum8); else pass_cnt++;
        dones = 0;
        for (t = 0; t < 12; t++) begin @(posedge clk); #1; if (done8) dones++; end
        total++; if (dones !== 0) $display("FAIL abort_no_done: got %0d expected 0", dones); else pass_cnt++;
        run_op(0, 16'h0033, 16'h0044, 1'b1, lat, bn);
        total++; if ({lat, sum8} !== {32'd8, 8'h78})
            $display("FAIL abort_recover: got lat=%0d sum=%h expected lat=8 sum=78", lat, sum8); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_digit4();
        int lat, bn;
        run_op(1, 16'hFFFF, 16'h0001, 1'b0, lat, bn);
        total++; if (lat !== 4) $display("FAIL d4_latency: got %0d expected 4", lat); else pass_cnt++;
        total++; if ({co4, sum4} !== {1'b1, 16'h0000})
            $display("FAIL d4_wrap: got co=%b sum=%h expected co=1 sum=0000", co4, sum4); else pass_cnt++;
        @(posedge clk); #1;
        run_op(1, 16'h8000, 16'h8000, 1'b0, lat, bn);
        total++; if ({co4, ov4, sum4} !== {2'b11, 16'h0000})
            $display("FAIL d4_overflow: got co=%b ov=%b sum=%h expected co=1 ov=1 sum=0000", co4, ov4, sum4); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_digit16();
        int lat, bn;
        run_op(2, 16'hFFFF, 16'h0001, 1'b0, lat, bn);
        total++; if (lat !== 1) $display("FAIL d16_latency: got %0d expected 1", lat); else pass_cnt++;
        total++; if ({co16, sum16} !== {1'b1, 16'h0000})
            $display("FAIL d16_wrap: got co=%b sum=%h expected co=1 sum=0000", co16, sum16); else pass_cnt++;
        @(posedge clk); #1;
        run_op(2, 16'h7FFF, 16'h0001, 1'b0, lat, bn);
        total++; if ({co16, ov16, sum16} !== {2'b01, 16'h8000})
            $display("FAIL d16_overflow: got co=%b ov=%b sum=%h expected co=0 ov=1 sum=8000", co16, ov16, sum16); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    initial begin
        st8 = 1'b0; st4 = 1'b0; st16 = 1'b0;
        a8 = '0; b8 = '0; ci8 = 1'b0;
        a4 = '0; b4 = '0; ci4 = 1'b0;
        a16 = '0; b16 = '0; ci16 = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_reset_mid_run();
        test_digit4();
        test_digit16();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
